pipe_decode: RTL and testbench

PIPE_DECODE -- requirements
Module: pipe_decode

---
 rtl/pipe_decode_if.sv | 29 ++
 rtl/pipe_decode.sv | 117 +++++++++++
 tb/tb_pipe_decode.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_decode_if.sv
// Fetch-to-decode, writeback and D/E register signals of the decode stage.
// The master drives the fetch/writeback side; the slave (decode) returns e_*.
interface pipe_decode_if #(
  parameter int DATA_W = 64
);
  logic [3:0]        d_icode, d_ifun, d_rA, d_rB;
  logic [DATA_W-1:0] d_valC, d_valP;
  logic              d_valid;
  logic              stall, bubble;
  logic [3:0]        w_dstE, w_dstM;
  logic [DATA_W-1:0] w_valE, w_valM;
  logic              e_valid;
  logic [3:0]        e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM;
  logic [DATA_W-1:0] e_valA, e_valB, e_valC;

  modport master (
    output d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valid,
    output stall, bubble, w_dstE, w_dstM, w_valE, w_valM,
    input  e_valid, e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM,
    input  e_valA, e_valB, e_valC
  );

  modport slave (
    input  d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valid,
    input  stall, bubble, w_dstE, w_dstM, w_valE, w_valM,
    output e_valid, e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM,
    output e_valA, e_valB, e_valC
  );
endinterface

// File: rtl/pipe_decode.sv
// Y86-style decode stage: register-ID decode, register file with same-cycle
// writeback bypass, operand select and the D/E pipeline register.
module pipe_decode #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int RSP_ID = 4
) (
  input logic         clk,
  input logic         reset,
  pipe_decode_if.slave bus
);
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RSP     = 4'(RSP_ID);
  localparam logic [3:0] NREG_ID = 4'(NREG);

  typedef struct packed {
    logic              valid;
    logic [3:0]        icode, ifun, srcA, srcB, dstE, dstM;
    logic [DATA_W-1:0] valA, valB, valC;
  } de_t;

  logic [DATA_W-1:0] rf [NREG];
  logic [3:0]        srcA, srcB, dstE, dstM;
  logic [DATA_W-1:0] rdA, rdB, valA;
  de_t               de_q, de_nop, de_nxt;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (bus.d_icode)
      4'd2:  begin srcA = bus.d_rA;                   dstE = bus.d_rB; end
      4'd3:  begin                                    dstE = bus.d_rB; end
      4'd4:  begin srcA = bus.d_rA; srcB = bus.d_rB;                   end
      4'd5:  begin srcB = bus.d_rB;                   dstM = bus.d_rA; end
      4'd6:  begin srcA = bus.d_rA; srcB = bus.d_rB;  dstE = bus.d_rB; end
      4'd8:  begin srcB = RSP;                        dstE = RSP;      end
      4'd9:  begin srcA = RSP;      srcB = RSP;       dstE = RSP;      end
      4'd10: begin srcA = bus.d_rA; srcB = RSP;       dstE = RSP;      end
      4'd11: begin srcA = RSP;      srcB = RSP;       dstE = RSP;  dstM = bus.d_rA; end
      default: ;
    endcase
  end

  // Reads see this cycle's writeback (M over E) so there is no RAW gap.
  always_comb begin
    rdA = '0;
    if (srcA < NREG_ID) begin
      if (srcA == bus.w_dstM)      rdA = bus.w_valM;
      else if (srcA == bus.w_dstE) rdA = bus.w_valE;
      else                         rdA = rf[srcA];
    end
  end

  always_comb begin
    rdB = '0;
    if (srcB < NREG_ID) begin
      if (srcB == bus.w_dstM)      rdB = bus.w_valM;
      else if (srcB == bus.w_dstE) rdB = bus.w_valE;
      else                         rdB = rf[srcB];
    end
  end

  assign valA = (bus.d_icode == 4'd7 || bus.d_icode == 4'd8) ? bus.d_valP : rdA;

  always_comb begin
    de_nop       = '0;
    de_nop.icode = 4'h1;
    de_nop.srcA  = RNONE;
    de_nop.srcB  = RNONE;
    de_nop.dstE  = RNONE;
    de_nop.dstM  = RNONE;
  end

  always_comb begin
    de_nxt       = '0;
    de_nxt.valid = 1'b1;
    de_nxt.icode = bus.d_icode;
    de_nxt.ifun  = bus.d_ifun;
    de_nxt.srcA  = srcA;
    de_nxt.srcB  = srcB;
    de_nxt.dstE  = dstE;
    de_nxt.dstM  = dstM;
    de_nxt.valA  = valA;
    de_nxt.valB  = rdB;
    de_nxt.valC  = bus.d_valC;
  end

  // M is written last so it wins when both ports target one register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (bus.w_dstE < NREG_ID) rf[bus.w_dstE] <= bus.w_valE;
      if (bus.w_dstM < NREG_ID) rf[bus.w_dstM] <= bus.w_valM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                           de_q <= de_nop;
    else if (bus.stall)                  de_q <= de_q;
    else if (bus.bubble || !bus.d_valid) de_q <= de_nop;
    else                                 de_q <= de_nxt;
  end

  assign bus.e_valid = de_q.valid;
  assign bus.e_icode = de_q.icode;
  assign bus.e_ifun  = de_q.ifun;
  assign bus.e_srcA  = de_q.srcA;
  assign bus.e_srcB  = de_q.srcB;
  assign bus.e_dstE  = de_q.dstE;
  assign bus.e_dstM  = de_q.dstM;
  assign bus.e_valA  = de_q.valA;
  assign bus.e_valB  = de_q.valB;
  assign bus.e_valC  = de_q.valC;
endmodule

// File: tb/tb_pipe_decode.sv
// Directed bench for pipe_decode: decode, bypass, writeback, stall/bubble, reset.
module tb_pipe_decode;
  localparam int DATA_W = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  pipe_decode_if #(.DATA_W(DATA_W)) bus ();
  pipe_decode #(.DATA_W(DATA_W), .NREG(15), .RSP_ID(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                     input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
    bus.d_icode = ic; bus.d_ifun = fn; bus.d_rA = ra; bus.d_rB = rb;
    bus.d_valC = vc; bus.d_valP = vp; bus.d_valid = 1'b1;
  endtask

  task automatic wb(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm,
                    input logic [63:0] vm);
    bus.w_dstE = de; bus.w_valE = ve; bus.w_dstM = dm; bus.w_valM = vm;
  endtask

  task automatic test_reset();
    dec(4'd1, 4'd0, 4'hF, 4'hF, 64'd0, 64'd0);
    bus.stall = 1'b0; bus.bubble = 1'b0;
    reset = 1'b1;
    wb(4'd1, 64'h55, 4'hF, 64'd0);
    step();
    total++; if (bus.e_icode !== 4'h1) begin bad++; $display("FAIL reset_icode got=%h exp=1", bus.e_icode); end
    total++; if (bus.e_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.e_valid); end
    total++; if ({bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM} !== 16'hFFFF) begin bad++;
      $display("FAIL reset_ids got=%h exp=ffff", {bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM}); end
    total++; if ({bus.e_valA, bus.e_valB, bus.e_valC} !== 192'd0) begin bad++; $display("FAIL reset_vals got nonzero exp=0"); end
    reset = 1'b0;
    wb(4'hF, 64'd0, 4'hF, 64'd0);
    dec(4'd2, 4'd0, 4'd1, 4'd6, 64'd0, 64'd0);
    step();
    total++; if (bus.e_valA !== 64'd0) begin bad++; $display("FAIL reset_wb_discard got=%h exp=0", bus.e_valA); end
  endtask

  task automatic test_opq();
    wb(4'd2, 64'd5, 4'd3, 64'd7);
    dec(4'd1, 4'd0, 4'hF, 4'hF, 64'd0, 64'd0);
    step();
    wb(4'hF, 64'd0, 4'hF, 64'd0);
    dec(4'd6, 4'd0, 4'd2, 4'd3, 64'd0, 64'd0);
    step();
    total++; if (bus.e_valA !== 64'd5) begin bad++; $display("FAIL opq_valA got=%h exp=5", bus.e_valA); end
    total++; if (bus.e_valB !== 64'd7) begin bad++; $display("FAIL opq_valB got=%h exp=7", bus.e_valB); end
    total++; if ({bus.e_dstE, bus.e_dstM} !== 8'h3F) begin bad++; $display("FAIL opq_dst got=%h exp=3f", {bus.e_dstE, bus.e_dstM}); end
    total++; if ({bus.e_valid, bus.e_icode, bus.e_srcA, bus.e_srcB} !== 13'h1623) begin bad++;
      $display("FAIL opq_fields got=%h exp=1623", {bus.e_valid, bus.e_icode, bus.e_srcA, bus.e_srcB}); end
  endtask

  task automatic test_bypass();
    wb(4'd2, 64'd9, 4'hF, 64'd0);
    dec(4'd2, 4'd0, 4'd2, 4'd8, 64'd0, 64'd0);
    step();
    total++; if (bus.e_valA !== 64'd9) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=9", bus.e_valA); end
    total++; if (bus.e_dstE !== 4'd8) begin bad++; $display("FAIL rrmov_dstE got=%h exp=8", bus.e_dstE); end
    wb(4'hF, 64'd0, 4'hF, 64'd0);
    step();
    total++; if (bus.e_valA !== 64'd9) begin bad++; $display("FAIL bypass_later got=%h exp=9", bus.e_valA); end
  endtask

  task automatic test_same_dst();
    wb(4'd5, 64'd1, 4'd5, 64'd2);
    dec(4'd1, 4'd0, 4'hF, 4'hF, 64'd0, 64'd0);
    step();
    wb(4'd6, 64'h11, 4'd6, 64'h22);
    dec(4'd4, 4'd0, 4'd6, 4'd5, 64'd0, 64'd0);
    step();
    total++; if (bus.e_valB !== 64'd2) begin bad++; $display("FAIL same_dst_m_wins got=%h exp=2", bus.e_valB); end
    total++; if (bus.e_valA !== 64'h22) begin bad++; $display("FAIL bypass_m_prio got=%h exp=22", bus.e_valA); end
  endtask

  task automatic test_call_pop();
    wb(4'd4, 64'h100, 4'hF, 64'd0);
    dec(4'd1, 4'd0, 4'hF, 4'hF, 64'd0, 64'd0);
    step();
    wb(4'hF, 64'd0, 4'hF, 64'd0);
    dec(4'd8, 4'd0, 4'hF, 4'hF, 64'h1234, 64'h40);
    step();
    total++; if (bus.e_valA !== 64'h40) begin bad++; $display("FAIL call_valA got=%h exp=40", bus.e_valA); end
    total++; if (bus.e_valB !== 64'h100) begin bad++; $display("FAIL call_valB got=%h exp=100", bus.e_valB); end
    total++; if ({bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM} !== 16'hF44F) begin bad++;
      $display("FAIL call_ids got=%h exp=f44f", {bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM}); end
    total++; if (bus.e_valC !== 64'h1234) begin bad++; $display("FAIL call_valC got=%h exp=1234", bus.e_valC); end
    dec(4'd11, 4'd0, 4'd7, 4'hF, 64'd0, 64'd0);
    step();
    total++; if ({bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM} !== 16'h4447) begin bad++;
      $display("FAIL pop_ids got=%h exp=4447", {bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM}); end
    total++; if (bus.e_valA !== 64'h100) begin bad++; $display("FAIL pop_valA got=%h exp=100", bus.e_valA); end
  endtask

  task automatic test_stall_bubble();
    // r2=9, r3=7 from earlier tests
    dec(4'd6, 4'd1, 4'd2, 4'd3, 64'h77, 64'd0);
    step();
    total++; if ({bus.e_icode, bus.e_ifun} !== 8'h61) begin bad++; $display("FAIL stall_load got=%h exp=61", {bus.e_icode, bus.e_ifun}); end
    dec(4'd3, 4'd0, 4'd1, 4'd1, 64'd0, 64'd0);
    bus.stall = 1'b1;
    step();
    total++; if ({bus.e_icode, bus.e_valA} !== {4'h6, 64'd9}) begin bad++; $display("FAIL stall_hold1 icode=%h valA=%h exp=6/9", bus.e_icode, bus.e_valA); end
    bus.bubble = 1'b1;
    step();
    total++; if ({bus.e_valid, bus.e_icode, bus.e_valC} !== {1'b1, 4'h6, 64'h77}) begin bad++;
      $display("FAIL stall_over_bubble valid=%b icode=%h valC=%h exp=1/6/77", bus.e_valid, bus.e_icode, bus.e_valC); end
    bus.bubble = 1'b0;
    wb(4'd3, 64'h33, 4'hF, 64'd0);
    step();
    total++; if ({bus.e_valB, bus.e_dstE} !== {64'd7, 4'd3}) begin bad++; $display("FAIL stall_hold3 valB=%h dstE=%h exp=7/3", bus.e_valB, bus.e_dstE); end
    wb(4'hF, 64'd0, 4'hF, 64'd0);
    bus.stall = 1'b0; bus.bubble = 1'b1;
    step();
    total++; if ({bus.e_valid, bus.e_icode, bus.e_srcA, bus.e_valA} !== {1'b0, 4'h1, 4'hF, 64'd0}) begin bad++;
      $display("FAIL bubble_nop valid=%b icode=%h srcA=%h valA=%h", bus.e_valid, bus.e_icode, bus.e_srcA, bus.e_valA); end
    bus.bubble = 1'b0;
    dec(4'd6, 4'd0, 4'd2, 4'd3, 64'd0, 64'd0);
    step();
    total++; if (bus.e_valB !== 64'h33) begin bad++; $display("FAIL wb_during_stall got=%h exp=33", bus.e_valB); end
  endtask

  task automatic test_invalid_unknown();
    dec(4'd6, 4'd0, 4'd2, 4'd3, 64'h5, 64'd0);
    bus.d_valid = 1'b0;
    step();
    total++; if ({bus.e_valid, bus.e_icode, bus.e_dstE, bus.e_valA} !== {1'b0, 4'h1, 4'hF, 64'd0}) begin bad++;
      $display("FAIL dvalid0 valid=%b icode=%h dstE=%h valA=%h", bus.e_valid, bus.e_icode, bus.e_dstE, bus.e_valA); end
    dec(4'd12, 4'd3, 4'd2, 4'd3, 64'hAB, 64'd0);
    step();
    total++; if ({bus.e_valid, bus.e_icode, bus.e_ifun, bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM} !== 25'h1C3FFFF) begin bad++;
      $display("FAIL unknown_fields got=%h exp=1c3ffff", {bus.e_valid, bus.e_icode, bus.e_ifun, bus.e_srcA, bus.e_srcB, bus.e_dstE, bus.e_dstM}); end
    total++; if ({bus.e_valA, bus.e_valB, bus.e_valC} !== {64'd0, 64'd0, 64'hAB}) begin bad++;
      $display("FAIL unknown_vals valA=%h valB=%h valC=%h", bus.e_valA, bus.e_valB, bus.e_valC); end
  endtask

  task automatic test_reset_stall();
    wb(4'd1, 64'h55, 4'hF, 64'd0);
    dec(4'd2, 4'd0, 4'd1, 4'd6, 64'd0, 64'd0);
    step();
    total++; if (bus.e_valA !== 64'h55) begin bad++; $display("FAIL pre_reset_r1 got=%h exp=55", bus.e_valA); end
    wb(4'hF, 64'd0, 4'hF, 64'd0);
    bus.stall = 1'b1; reset = 1'b1;
    step();
    total++; if ({bus.e_valid, bus.e_icode, bus.e_dstE, bus.e_valA} !== {1'b0, 4'h1, 4'hF, 64'd0}) begin bad++;
      $display("FAIL reset_over_stall valid=%b icode=%h dstE=%h valA=%h", bus.e_valid, bus.e_icode, bus.e_dstE, bus.e_valA); end
    reset = 1'b0; bus.stall = 1'b0;
    step();
    total++; if ({bus.e_valid, bus.e_icode, bus.e_valA} !== {1'b1, 4'h2, 64'd0}) begin bad++;
      $display("FAIL post_reset_r1 valid=%b icode=%h valA=%h exp=1/2/0", bus.e_valid, bus.e_icode, bus.e_valA); end
  endtask

  initial begin
    test_reset();
    test_opq();
    test_bypass();
    test_same_dst();
    test_call_pop();
    test_stall_bubble();
    test_invalid_unknown();
    test_reset_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
